// File: rtl/mult_sequencer.sv
// Shift-add multiply sequencer for EX; product commits to hi/lo WIDTH+1 cycles after start is accepted.
// Stalls IF/ID/EX while running. Flush aborts without committing. start is ignored while RUN.
module mult_sequencer #(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      count_q, count_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        // The most negative operand negates to itself, which read unsigned is the right magnitude.
        abs_a = (SIGNED && src_a[WIDTH-1]) ? -src_a : src_a;
        abs_b = (SIGNED && src_b[WIDTH-1]) ? -src_b : src_b;

        sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        acc_step = {sum, acc_q[WIDTH-1:1]};
        prod     = neg_q ? -acc_step : acc_step;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start && !flush) begin
                    state_d  = S_RUN;
                    mcand_d  = abs_a;
                    mplier_d = abs_b;
                    neg_d    = SIGNED & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                    acc_d    = '0;
                    count_d  = CW'(WIDTH);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d    = acc_step;
                    mplier_d = mplier_q >> 1;
                    count_d  = count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        state_d      = S_DONE;
                        {hi_d, lo_d} = prod;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // Gated by reset so a held start cannot freeze the pipe while reset is low.
    assign stall = reset & (((state_q != S_RUN) & start & !flush) |
                            ((state_q == S_RUN) & !flush));
    assign busy  = (state_q == S_RUN);
    assign done  = (state_q == S_DONE);
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer: a signed and an unsigned instance share stimulus; results are
// compared against constant vectors and a plain-arithmetic product model.
module tb_mult_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] src_a, src_b;
    logic         flush;
    logic         stall_s, busy_s, done_s, stall_u, busy_u, done_u;
    logic [W-1:0] hi_s, lo_s, hi_u, lo_u;

    int errors = 0;
    int checks = 0;

    logic [63:0] exp_s, exp_u;

    mult_sequencer #(.WIDTH(W), .SIGNED(1'b1)) dut_s (
        .clk(clk), .reset(reset), .start(start), .src_a(src_a), .src_b(src_b),
        .flush(flush), .stall(stall_s), .busy(busy_s), .done(done_s), .hi(hi_s), .lo(lo_s)
    );

    mult_sequencer #(.WIDTH(W), .SIGNED(1'b0)) dut_u (
        .clk(clk), .reset(reset), .start(start), .src_a(src_a), .src_b(src_b),
        .flush(flush), .stall(stall_u), .busy(busy_u), .done(done_u), .hi(hi_u), .lo(lo_u)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] prod_s(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, p;
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        p  = sa * sb;
        return p;
    endfunction

    function automatic logic [63:0] prod_u(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ua, ub;
        ua = {32'b0, a};
        ub = {32'b0, b};
        return ua * ub;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Entered at posedge+1; drives one cycle of inputs, checks, advances to next posedge+1.
    // e = {stall, busy, done}
    task automatic cyc(input logic st, input logic [31:0] a, input logic [31:0] b,
                       input logic fl, input logic [2:0] e, input string nm);
        start = st;
        src_a = a;
        src_b = b;
        flush = fl;
        #2;
        chk({nm, " ctl_s"}, {61'b0, stall_s, busy_s, done_s}, {61'b0, e});
        chk({nm, " ctl_u"}, {61'b0, stall_u, busy_u, done_u}, {61'b0, e});
        chk({nm, " hilo_s"}, {hi_s, lo_s}, exp_s);
        chk({nm, " hilo_u"}, {hi_u, lo_u}, exp_u);
        @(posedge clk);
        #1;
    endtask

    // One operation. chained: cycle 0 already happened in the previous DONE cycle.
    // flush_at: RUN cycle (1..W) to flush in, or -1. nxt: start the next op in DONE.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int flush_at,
                          input bit chained, input bit nxt, input logic [31:0] na,
                          input logic [31:0] nb, input bit dfl);
        if (!chained) cyc(1'b1, a, b, 1'b0, 3'b100, "start");
        for (int k = 1; k <= W; k++) begin
            if (k == flush_at) begin
                cyc(1'b1, $urandom, $urandom, 1'b1, 3'b010, "flush_run");
                cyc(1'b0, 32'h0, 32'h0, 1'b0, 3'b000, "after_flush");
                return;
            end
            cyc(1'b1, $urandom, $urandom, 1'b0, 3'b110, "run");
        end
        exp_s = prod_s(a, b);
        exp_u = prod_u(a, b);
        cyc(nxt, na, nb, dfl, {nxt & !dfl, 2'b01}, "done");
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp_s;
        logic [63:0] exp_u;
    } vec_t;

    vec_t        tbl[6];
    logic [31:0] ca, cb, na, nb;
    bit          ch, nx;
    int          fa;

    initial begin
        tbl[0] = '{32'd3,        32'd5,        64'h0000000000000000 | 64'hF,     64'h000000000000000F};
        tbl[1] = '{32'hFFFFFFFE, 32'd3,        64'hFFFFFFFF_FFFFFFFA,            64'h00000002_FFFFFFFA};
        tbl[2] = '{32'h80000000, 32'h80000000, 64'h40000000_00000000,            64'h40000000_00000000};
        tbl[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001,            64'hFFFFFFFE_00000001};
        tbl[4] = '{32'h0,        32'hDEADBEEF, 64'h0,                            64'h0};
        tbl[5] = '{32'h7FFFFFFF, 32'h80000000, 64'hC0000000_80000000,            64'h3FFFFFFF_80000000};

        exp_s = '0;
        exp_u = '0;
        reset = 1'b0;
        start = 1'b1;
        src_a = 32'd3;
        src_b = 32'd5;
        flush = 1'b0;
        #3;
        chk("reset ctl_s", {61'b0, stall_s, busy_s, done_s}, 64'h0);
        chk("reset ctl_u", {61'b0, stall_u, busy_u, done_u}, 64'h0);
        chk("reset hilo_s", {hi_s, lo_s}, 64'h0);
        chk("reset hilo_u", {hi_u, lo_u}, 64'h0);
        start = 1'b0;
        #20;
        reset = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 3'b000, "idle");

        for (int i = 0; i < 6; i++) begin
            run_op(tbl[i].a, tbl[i].b, -1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
            chk($sformatf("tbl%0d hilo_s", i), {hi_s, lo_s}, tbl[i].exp_s);
            chk($sformatf("tbl%0d hilo_u", i), {hi_u, lo_u}, tbl[i].exp_u);
        end

        // Flush mid-run: previous 3*5 result must survive.
        run_op(32'd3, 32'd5, -1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        run_op(32'd7, 32'd9, 10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("flush keeps lo", {32'h0, lo_s}, 64'hF);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 3'b000, "no_done_after_flush");

        // Back-to-back: 4*4 starts in the DONE cycle of 3*5.
        run_op(32'd3, 32'd5, -1, 1'b0, 1'b1, 32'd4, 32'd4, 1'b0);
        chk("chain first lo", {32'h0, lo_s}, 64'd15);
        run_op(32'd4, 32'd4, -1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("chain second lo", {32'h0, lo_s}, 64'd16);

        // flush with start in IDLE, and flush during DONE.
        cyc(1'b1, 32'd6, 32'd6, 1'b1, 3'b000, "flush_start_idle");
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 3'b000, "idle_after_ignored");
        run_op(32'hFFFFFFF9, 32'd11, -1, 1'b0, 1'b1, 32'd2, 32'd2, 1'b1);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 3'b000, "after_done_flush");

        // Randomized operations, with random chaining and flushes.
        ch = 1'b0;
        ca = $urandom;
        cb = $urandom;
        for (int i = 0; i < 16; i++) begin
            fa = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, W)) : -1;
            nx = (fa < 0) && ($urandom_range(0, 1) == 1) && (i < 15);
            na = $urandom;
            nb = $urandom;
            if (i == 3) na = 32'h80000000;
            run_op(ca, cb, fa, ch, nx, na, nb, 1'b0);
            ch = nx;
            ca = na;
            cb = nb;
        end

        // Asynchronous reset in cycle 20 of a run, start held high throughout.
        cyc(1'b1, 32'h12345678, 32'h9ABCDEF0, 1'b0, 3'b100, "rst_start");
        for (int k = 1; k < 20; k++) cyc(1'b1, $urandom, $urandom, 1'b0, 3'b110, "rst_run");
        start = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        exp_s = '0;
        exp_u = '0;
        chk("async rst ctl_s", {61'b0, stall_s, busy_s, done_s}, 64'h0);
        chk("async rst ctl_u", {61'b0, stall_u, busy_u, done_u}, 64'h0);
        chk("async rst hilo_s", {hi_s, lo_s}, 64'h0);
        chk("async rst hilo_u", {hi_u, lo_u}, 64'h0);
        @(posedge clk);
        #3;
        start = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 40; k++) cyc(1'b0, 32'h0, 32'h0, 1'b0, 3'b000, "post_rst_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
